fsm_mestre_envase: RTL and testbench
====================================

# fsm_mestre_envase

Master sequencer for the bottling line. Drives the conveyor motor and issues level-held commands to the filling and capping station FSMs, waiting on each station's completion flag. Counts finished bottles, and enforces a per-state watchdog and a cork-supply interlock. Sits between the operator buttons/sensors and the station FSMs; every station command originates here.

## Interface
Parameters:
- TIMEOUT_CICLOS, default 500_000_000 (10 s at 50 MHz): maximum cycles allowed in any waiting state before fault.
- LARGURA_CONTADOR, default 8: width of the bottle counter.

Ports:
- clk  input  1  50 MHz clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- botao_start  input  1  start request, debounced, level.
- botao_stop  input  1  stop request, debounced, level.
- sensor_pos_enchimento  input  1  bottle at filling position.
- sensor_pos_vedacao  input  1  bottle at capping position.
- sensor_rolhas_vazio  input  1  cork magazine empty.
- enchimento_concluido  input  1  completion flag from the filling FSM.
- vedacao_concluida  input  1  completion flag from the capping FSM.
- motor_esteira  output  1  conveyor motor on.
- cmd_enchimento  output  1  filling command, held while filling.
- cmd_vedacao  output  1  capping command, held while capping.
- contador_garrafas  output  LARGURA_CONTADOR  finished bottles.
- alarme  output  1  fault indicator.
- codigo_falha  output  2  00 none, 01 watchdog timeout, 10 no corks.

## Operation
- Moore FSM. motor_esteira, cmd_enchimento, cmd_vedacao and alarme are a pure decode of the state register.
- PARADO: all outputs 0. Enter TRANSP_ENCH when botao_start=1 and botao_stop=0.
- TRANSP_ENCH: motor=1. Enter ENCHENDO when sensor_pos_enchimento=1.
- ENCHENDO: cmd_enchimento=1. Enter LIBERA_ENCH when enchimento_concluido=1.
- LIBERA_ENCH: all commands 0. Enter TRANSP_VED when enchimento_concluido=0 (return-to-idle handshake).
- TRANSP_VED: motor=1. On sensor_pos_vedacao=1:
  - sensor_rolhas_vazio=1: go to FALHA with code 10.
  - otherwise: go to VEDANDO.
- VEDANDO: cmd_vedacao=1. Enter LIBERA_VED when vedacao_concluida=1.
- LIBERA_VED: wait for vedacao_concluida=0, then enter CONTA.
- CONTA: one cycle, contador_garrafas += 1 (wraps modulo 2^LARGURA_CONTADOR). Next state is PARADO if stop_pendente, else TRANSP_ENCH.
- FALHA: alarme=1, motor and commands 0. Leave to PARADO only when botao_stop=1, enchimento_concluido=0 and vedacao_concluida=0; codigo_falha clears to 00 on that exit.
- Stop handling:
  - In TRANSP_ENCH or TRANSP_VED, botao_stop=1 goes straight to PARADO, with priority over sensor inputs the same cycle.
  - In ENCHENDO, LIBERA_ENCH, VEDANDO or LIBERA_VED, botao_stop=1 sets stop_pendente. The cycle finishes through CONTA, then goes to PARADO. A bottle is never abandoned mid-station.
  - stop_pendente clears on entry to PARADO.
- botao_start is ignored outside PARADO. Start and stop asserted together in PARADO: stay in PARADO.
- Watchdog:
  - Cycle counter runs in TRANSP_ENCH, ENCHENDO, LIBERA_ENCH, TRANSP_VED, VEDANDO and LIBERA_VED.
  - Clears to 0 on every state change.
  - When it reaches TIMEOUT_CICLOS-1 and no exit condition is true that cycle, next state is FALHA with code 01. A legitimate exit the same cycle wins.
- Unreachable state encodings go to PARADO.

## Timing
- Reset (synchronous, at clk edge with reset=1): state PARADO; all outputs 0; contador_garrafas 0; codigo_falha 00; stop_pendente 0; watchdog 0. Reset mid-cycle drops the commands at that edge; the bottle count is lost.
- Every input-driven transition takes effect at the next rising clk edge. Outputs change on the same edge as the state.
- Latency:
  - start → motor_esteira=1: 1 cycle.
  - sensor_pos_enchimento → cmd_enchimento=1: 1 cycle.
  - enchimento_concluido → cmd_enchimento=0: 1 cycle.
- Counter increments on the edge leaving CONTA; CONTA lasts exactly 1 cycle.
- Timeout fires after exactly TIMEOUT_CICLOS cycles spent in one waiting state.

## Test plan
- Nominal cycle (TIMEOUT_CICLOS=64):
  - Stimulus: start pulse, pos_ench after 3 cycles, concluido high 5 cycles, pos_ved, vedacao_concluida pulse.
  - Required: motor, cmd_enchimento and cmd_vedacao each assert for the correct windows; contador_garrafas 0→1; FSM back in TRANSP_ENCH.
- Stop during ENCHENDO: cmd_enchimento stays 1 until concluido; cycle completes; counter=1; ends in PARADO with motor=0.
- Stop during TRANSP_VED with sensor_pos_vedacao=1 the same cycle: next state PARADO; cmd_vedacao never asserts; counter unchanged.
- Cork interlock: sensor_rolhas_vazio=1 on arrival at capping → alarme=1, codigo_falha=10, cmd_vedacao=0. Asserting stop returns to PARADO and clears the code to 00.
- Watchdog: hold sensor_pos_enchimento=0 for 64 cycles → FALHA with code 01 exactly at cycle 64. Repeat with the sensor rising at cycle 63 → no fault.
- Wrap and reset: LARGURA_CONTADOR=2, five cycles → count 1. Reset asserted in VEDANDO → all outputs 0 at the next edge.

Source files
------------

// File: rtl/fsm_mestre_envase.sv
// fsm_mestre_envase: bottling-line master sequencer with watchdog and cork interlock
module fsm_mestre_envase #(
  parameter int TIMEOUT_CICLOS   = 500_000_000,
  parameter int LARGURA_CONTADOR = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        botao_start,
  input  logic                        botao_stop,
  input  logic                        sensor_pos_enchimento,
  input  logic                        sensor_pos_vedacao,
  input  logic                        sensor_rolhas_vazio,
  input  logic                        enchimento_concluido,
  input  logic                        vedacao_concluida,
  output logic                        motor_esteira,
  output logic                        cmd_enchimento,
  output logic                        cmd_vedacao,
  output logic [LARGURA_CONTADOR-1:0] contador_garrafas,
  output logic                        alarme,
  output logic [1:0]                  codigo_falha
);
  localparam int WW = $clog2(TIMEOUT_CICLOS + 1);
  typedef enum logic [3:0] {
    PARADO, TRANSP_ENCH, ENCHENDO, LIBERA_ENCH, TRANSP_VED,
    VEDANDO, LIBERA_VED, CONTA, FALHA
  } estado_t;
  estado_t estado, prox;
  logic [WW-1:0] wd;
  logic [1:0] codigo_prox;
  logic stop_pendente, espera, na_estacao, timeout;
  always_comb begin
    espera = estado inside {TRANSP_ENCH, ENCHENDO, LIBERA_ENCH, TRANSP_VED, VEDANDO, LIBERA_VED};
    na_estacao = estado inside {ENCHENDO, LIBERA_ENCH, VEDANDO, LIBERA_VED};
    timeout = espera && (wd == WW'(TIMEOUT_CICLOS - 1));
    prox = estado;
    codigo_prox = codigo_falha;
    case (estado)
      PARADO:      prox = (botao_start && !botao_stop) ? TRANSP_ENCH : PARADO;
      TRANSP_ENCH: prox = botao_stop ? PARADO : sensor_pos_enchimento ? ENCHENDO : TRANSP_ENCH;
      ENCHENDO:    prox = enchimento_concluido ? LIBERA_ENCH : ENCHENDO;
      LIBERA_ENCH: prox = enchimento_concluido ? LIBERA_ENCH : TRANSP_VED;
      TRANSP_VED: begin
        prox = botao_stop ? PARADO : !sensor_pos_vedacao ? TRANSP_VED :
               sensor_rolhas_vazio ? FALHA : VEDANDO;
        codigo_prox = (prox == FALHA) ? 2'b10 : codigo_falha;
      end
      VEDANDO:     prox = vedacao_concluida ? LIBERA_VED : VEDANDO;
      LIBERA_VED:  prox = vedacao_concluida ? LIBERA_VED : CONTA;
      CONTA:       prox = stop_pendente ? PARADO : TRANSP_ENCH;
      FALHA: begin
        prox = (botao_stop && !enchimento_concluido && !vedacao_concluida) ? PARADO : FALHA;
        codigo_prox = (prox == PARADO) ? 2'b00 : codigo_falha;
      end
      default:     prox = PARADO;
    endcase
    // a legitimate exit on the deadline cycle takes precedence over the fault
    if (timeout && prox == estado) begin
      prox = FALHA;
      codigo_prox = 2'b01;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= PARADO;
      wd <= '0;
      stop_pendente <= 1'b0;
      contador_garrafas <= '0;
      codigo_falha <= 2'b00;
    end else begin
      estado <= prox;
      codigo_falha <= codigo_prox;
      wd <= (espera && prox == estado) ? wd + WW'(1) : '0;
      stop_pendente <= (prox == PARADO) ? 1'b0 : (botao_stop && na_estacao) ? 1'b1 : stop_pendente;
      contador_garrafas <= contador_garrafas + LARGURA_CONTADOR'(estado == CONTA);
    end
  end
  assign motor_esteira  = (estado == TRANSP_ENCH) || (estado == TRANSP_VED);
  assign cmd_enchimento = (estado == ENCHENDO);
  assign cmd_vedacao    = (estado == VEDANDO);
  assign alarme         = (estado == FALHA);
endmodule

// File: tb/tb_fsm_mestre_envase.sv
// tb_fsm_mestre_envase: directed self-checking bench for the bottling master sequencer
module tb_fsm_mestre_envase;
  logic clk = 1'b0, reset = 1'b1;
  logic botao_start = 0, botao_stop = 0, pos_ench = 0, pos_ved = 0, vazio = 0, ench = 0, ved = 0;
  logic motor_esteira, cmd_enchimento, cmd_vedacao, alarme;
  logic [1:0] contador_garrafas, codigo_falha;
  logic [3:0] o;
  int errors = 0, checks = 0;
  assign o = {motor_esteira, cmd_enchimento, cmd_vedacao, alarme};
  always #5 clk = ~clk;
  fsm_mestre_envase #(.TIMEOUT_CICLOS(64), .LARGURA_CONTADOR(2)) dut (
    .clk(clk), .reset(reset), .botao_start(botao_start), .botao_stop(botao_stop),
    .sensor_pos_enchimento(pos_ench), .sensor_pos_vedacao(pos_ved),
    .sensor_rolhas_vazio(vazio), .enchimento_concluido(ench), .vedacao_concluida(ved),
    .motor_esteira(motor_esteira), .cmd_enchimento(cmd_enchimento), .cmd_vedacao(cmd_vedacao),
    .contador_garrafas(contador_garrafas), .alarme(alarme), .codigo_falha(codigo_falha));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_ved;
    pos_ench = 1; tick; pos_ench = 0;
    ench = 1; tick; ench = 0; tick;
  endtask

  task automatic finish_ved;
    pos_ved = 1; tick; pos_ved = 0;
    ved = 1; tick; ved = 0; tick; tick;
  endtask

  task automatic test_reset;
    reset = 1; tick; tick;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b want 0000", o); end
    checks++; if (contador_garrafas !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", contador_garrafas); end
    checks++; if (codigo_falha !== 2'b00) begin errors++; $display("FAIL reset_code: got %b want 00", codigo_falha); end
    reset = 0;
  endtask

  task automatic test_nominal;
    botao_start = 1; tick; botao_start = 0;
    checks++; if (o !== 4'b1000) begin errors++; $display("FAIL nom_start_motor: got %b want 1000", o); end
    tick; tick; pos_ench = 1; tick; pos_ench = 0;
    checks++; if (o !== 4'b0100) begin errors++; $display("FAIL nom_cmd_ench: got %b want 0100", o); end
    ench = 1; tick;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL nom_ench_release: got %b want 0000", o); end
    repeat (4) tick;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL nom_ench_hold: got %b want 0000", o); end
    ench = 0; tick;
    checks++; if (o !== 4'b1000) begin errors++; $display("FAIL nom_transp_ved: got %b want 1000", o); end
    pos_ved = 1; tick; pos_ved = 0; tick;
    checks++; if (o !== 4'b0010) begin errors++; $display("FAIL nom_cmd_ved: got %b want 0010", o); end
    ved = 1; tick; ved = 0; tick;
    checks++; if (o !== 4'b0000 || contador_garrafas !== 2'd0) begin errors++; $display("FAIL nom_conta: got %b/%0d want 0000/0", o, contador_garrafas); end
    tick;
    checks++; if (o !== 4'b1000 || contador_garrafas !== 2'd1) begin errors++; $display("FAIL nom_loop: got %b/%0d want 1000/1", o, contador_garrafas); end
  endtask

  task automatic test_stop_enchendo;
    pos_ench = 1; tick; pos_ench = 0;
    botao_stop = 1; tick; botao_stop = 0; tick;
    checks++; if (o !== 4'b0100) begin errors++; $display("FAIL stopench_hold_cmd: got %b want 0100", o); end
    ench = 1; tick; ench = 0; tick;
    checks++; if (o !== 4'b1000) begin errors++; $display("FAIL stopench_continue: got %b want 1000", o); end
    finish_ved;
    checks++; if (o !== 4'b0000 || contador_garrafas !== 2'd2) begin errors++; $display("FAIL stopench_parado: got %b/%0d want 0000/2", o, contador_garrafas); end
  endtask

  task automatic test_stop_transp_ved;
    botao_start = 1; tick; botao_start = 0;
    go_ved;
    botao_stop = 1; pos_ved = 1; tick; botao_stop = 0; pos_ved = 0;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL stopved_parado: got %b want 0000", o); end
    tick;
    checks++; if (o !== 4'b0000 || contador_garrafas !== 2'd2) begin errors++; $display("FAIL stopved_idle: got %b/%0d want 0000/2", o, contador_garrafas); end
  endtask

  task automatic test_cork;
    botao_start = 1; tick; botao_start = 0;
    go_ved;
    vazio = 1; pos_ved = 1; tick; pos_ved = 0; tick;
    checks++; if (o !== 4'b0001 || codigo_falha !== 2'b10) begin errors++; $display("FAIL cork_fault: got %b/%b want 0001/10", o, codigo_falha); end
    botao_stop = 1; ench = 1; tick;
    checks++; if (o !== 4'b0001) begin errors++; $display("FAIL cork_blocked_exit: got %b want 0001", o); end
    ench = 0; tick; botao_stop = 0; vazio = 0;
    checks++; if (o !== 4'b0000 || codigo_falha !== 2'b00) begin errors++; $display("FAIL cork_clear: got %b/%b want 0000/00", o, codigo_falha); end
  endtask

  task automatic test_watchdog;
    botao_start = 1; tick; botao_start = 0;
    repeat (63) tick;
    checks++; if (o !== 4'b1000) begin errors++; $display("FAIL wd_cycle64: got %b want 1000", o); end
    tick;
    checks++; if (o !== 4'b0001 || codigo_falha !== 2'b01) begin errors++; $display("FAIL wd_fault: got %b/%b want 0001/01", o, codigo_falha); end
    botao_stop = 1; tick; botao_stop = 0;
    botao_start = 1; tick; botao_start = 0;
    repeat (63) tick;
    pos_ench = 1; tick; pos_ench = 0;
    checks++; if (o !== 4'b0100 || codigo_falha !== 2'b00) begin errors++; $display("FAIL wd_exit_wins: got %b/%b want 0100/00", o, codigo_falha); end
    ench = 1; tick; ench = 0; tick;
    finish_ved;
    checks++; if (o !== 4'b1000 || contador_garrafas !== 2'd3) begin errors++; $display("FAIL wd_bottle: got %b/%0d want 1000/3", o, contador_garrafas); end
  endtask

  task automatic test_wrap_reset;
    go_ved; finish_ved;
    checks++; if (contador_garrafas !== 2'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", contador_garrafas); end
    go_ved; finish_ved;
    checks++; if (contador_garrafas !== 2'd1) begin errors++; $display("FAIL wrap_fifth: got %0d want 1", contador_garrafas); end
    go_ved;
    pos_ved = 1; tick; pos_ved = 0;
    checks++; if (o !== 4'b0010) begin errors++; $display("FAIL rst_vedando: got %b want 0010", o); end
    reset = 1; tick; reset = 0;
    checks++; if (o !== 4'b0000 || contador_garrafas !== 2'd0 || codigo_falha !== 2'b00) begin errors++; $display("FAIL rst_mid: got %b/%0d/%b want 0000/0/00", o, contador_garrafas, codigo_falha); end
    tick;
    checks++; if (o !== 4'b0000) begin errors++; $display("FAIL rst_stays_idle: got %b want 0000", o); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_stop_enchendo;
    test_stop_transp_ved;
    test_cork;
    test_watchdog;
    test_wrap_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
